// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for fp_div_seq.
// master drives operands and accepts results; slave is the divider.
interface fp_div_seq_if #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NEXP+NSIG:0]   a;
    logic [NEXP+NSIG:0]   b;
    logic                 out_valid;
    logic                 out_ready;
    logic [NEXP+NSIG:0]   q;
    logic [4:0]           flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, flags
    );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential q = a / b: classify, restoring significand divide, normalise, RNE round.
// Define DIV_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fp_div_seq #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_div_seq_if.slave bus
);
    localparam int W  = NEXP + NSIG + 1;
    localparam int EW = NEXP + 2;
    localparam int QW = NSIG + 3;
    localparam int RW = NSIG + 2;
    localparam int CW = $clog2(QW + 1);
    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (NEXP-1)) - 1);
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << NEXP) - 1);
    localparam logic signed [EW-1:0] EONE  = EW'(1);
    localparam logic signed [EW-1:0] EZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_t;

    typedef struct packed {
        logic zero;
        logic sub;
        logic inf;
        logic nan;
        logic snan;
    } cls_t;

    function automatic cls_t classify(input logic [W-1:0] x);
        cls_t c;
        logic [NEXP-1:0] xe;
        logic [NSIG-1:0] xf;
        xe = x[W-2:NSIG];
        xf = x[NSIG-1:0];
        c.zero = (xe == '0) && (xf == '0);
        c.sub  = (xe == '0) && (xf != '0);
        c.inf  = (&xe) && (xf == '0);
        c.nan  = (&xe) && (xf != '0);
        c.snan = c.nan && !xf[NSIG-1];
        return c;
    endfunction

    function automatic void unpack(input logic [W-1:0] x,
                                   output logic [NSIG:0] m,
                                   output logic signed [EW-1:0] e);
        logic [NEXP-1:0] xe;
        xe = x[W-2:NSIG];
        m  = {1'b1, x[NSIG-1:0]};
        e  = $signed({2'b00, xe});
`ifdef DIV_SUBNORMAL_EN
        // subnormal: unit exponent, then slide the leading one up to the hidden position
        if (xe == '0) begin
            m = {1'b0, x[NSIG-1:0]};
            e = EONE;
            for (int i = 0; i < NSIG; i++) begin
                if (!m[NSIG]) begin
                    m = m << 1;
                    e = e - EONE;
                end
            end
        end
`endif
    endfunction

    state_t state, nstate;

    logic [W-1:0]           ra, rb, qr;
    logic [4:0]             flr;
    logic [NSIG:0]          mb;
    logic [RW-1:0]          rem;
    logic [QW-1:0]          quo;
    logic signed [EW-1:0]   er;
    logic                   sgn, spec;
    logic [CW-1:0]          cnt;

    // PREP combinational
    cls_t                   ca, cb;
    logic                   sp_hit;
    logic [W-1:0]           sp_q;
    logic [4:0]             sp_flags;
    logic [NSIG:0]          ma_n, mb_n;
    logic signed [EW-1:0]   ea_n, eb_n;
    logic                   sgn_ab;

    // ITER combinational
    logic                   q_bit;
    logic [RW-1:0]          r_step;

    // ROUND combinational
    logic [QW-1:0]          qn;
    logic signed [EW-1:0]   en, eo, sh;
    logic [NSIG+1:0]        sig, rnd;
    logic                   stk, grd, inc, tiny;
    logic [W-1:0]           rq;
    logic [4:0]             rflags;

    always_comb begin
        ca       = classify(ra);
        cb       = classify(rb);
`ifdef DIV_SUBNORMAL_EN
`else
        ca.zero  = ca.zero | ca.sub;
        cb.zero  = cb.zero | cb.sub;
`endif
        unpack(ra, ma_n, ea_n);
        unpack(rb, mb_n, eb_n);
        sgn_ab   = ra[W-1] ^ rb[W-1];
        sp_hit   = 1'b1;
        sp_q     = {sgn_ab, {NEXP{1'b1}}, {NSIG{1'b0}}};
        sp_flags = '0;
        if (ca.nan || cb.nan) begin
            sp_q        = QNAN;
            sp_flags[4] = ca.snan | cb.snan;
        end else if ((ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
            sp_q        = QNAN;
            sp_flags[4] = 1'b1;
        end else if (cb.zero) begin
            sp_flags[3] = 1'b1;
        end else if (ca.inf) begin
            sp_flags    = '0;
        end else if (ca.zero || cb.inf) begin
            sp_q        = {sgn_ab, {(W-1){1'b0}}};
        end else begin
            sp_hit      = 1'b0;
        end
    end

    always_comb begin
        q_bit  = (rem >= {1'b0, mb});
        r_step = q_bit ? rem - {1'b0, mb} : rem;
    end

    always_comb begin
        qn   = quo;
        en   = er;
        if (!quo[QW-1]) begin
            qn = {quo[QW-2:0], 1'b0};
            en = er - EONE;
        end
        // hidden, fraction, guard; everything below folds into sticky
        sig  = qn[QW-1:1];
        stk  = qn[0] | (rem != '0);
        tiny = 1'b0;
        sh   = EONE - en;
`ifdef DIV_SUBNORMAL_EN
        if (en <= EZERO) begin
            tiny = 1'b1;
            for (int i = 0; i < RW; i++) begin
                if (EW'(i) < sh) begin
                    stk = stk | sig[0];
                    sig = sig >> 1;
                end
            end
        end
`endif
        grd  = sig[0];
        inc  = grd & (stk | sig[1]);
        rnd  = {1'b0, sig[NSIG+1:1]} + {{(NSIG+1){1'b0}}, inc};
        eo   = en;
        if (rnd[NSIG+1]) begin
            rnd = rnd >> 1;
            eo  = en + EONE;
        end
        rq     = {sgn, eo[NEXP-1:0], rnd[NSIG-1:0]};
        rflags = {4'b0000, grd | stk};
        if (eo >= EMAX) begin
            rq     = {sgn, {NEXP{1'b1}}, {NSIG{1'b0}}};
            rflags = 5'b00101;
        end else if (tiny) begin
            // a round carry into rnd[NSIG] lands on the smallest normal exponent
            rq     = {sgn, {(NEXP-1){1'b0}}, rnd[NSIG], rnd[NSIG-1:0]};
            rflags = {3'b000, grd | stk, grd | stk};
        end else if (eo <= EZERO) begin
            rq     = {sgn, {(W-1){1'b0}}};
            rflags = 5'b00011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // specials also pass through ROUND so both paths expose results on the same kind of edge
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (bus.in_valid) nstate = PREP;
            PREP:    nstate = sp_hit ? ROUND : ITER;
            ITER:    if (cnt == CW'(QW-1)) nstate = ROUND;
            ROUND:   nstate = DONE;
            DONE:    if (bus.out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            mb   <= '0;
            rem  <= '0;
            quo  <= '0;
            er   <= '0;
            sgn  <= 1'b0;
            spec <= 1'b0;
            cnt  <= '0;
            qr   <= '0;
            flr  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    ra <= bus.a;
                    rb <= bus.b;
                end
                PREP: begin
                    sgn  <= sgn_ab;
                    spec <= sp_hit;
                    cnt  <= '0;
                    quo  <= '0;
                    rem  <= {1'b0, ma_n};
                    mb   <= mb_n;
                    er   <= ea_n - eb_n + BIAS;
                    if (sp_hit) begin
                        qr  <= sp_q;
                        flr <= sp_flags;
                    end
                end
                ITER: begin
                    rem <= {r_step[RW-2:0], 1'b0};
                    quo <= {quo[QW-2:0], q_bit};
                    cnt <= cnt + CW'(1);
                end
                ROUND: if (!spec) begin
                    qr  <= rq;
                    flr <= rflags;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.q         = qr;
    assign bus.flags     = flr;
endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq (bfloat16): values, flags, latency, backpressure, reset.
module tb_fp_div_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [15:0] q;
        logic [4:0]  fl;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    fp_div_seq_if #(.NEXP(8), .NSIG(7)) bus();
    fp_div_seq #(.NEXP(8), .NSIG(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                          input logic [15:0] eq, input logic [4:0] ef, input int elat,
                          input int hold);
        exp_t e;
        int lat;
        int n;
        sb_q.push_back('{eq, ef, elat});
        @(negedge clk);
        bus.a = xa;
        bus.b = xb;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb_q.pop_front();
        if (!bus.out_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_lat"}, lat, e.lat);
        chk({tag, "_q"}, bus.q, e.q);
        chk({tag, "_fl"}, bus.flags, e.fl);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_bp_q"}, bus.q, e.q);
            chk({tag, "_bp_fl"}, bus.flags, e.fl);
            chk({tag, "_bp_ov"}, bus.out_valid, 1);
            chk({tag, "_bp_ir"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk({tag, "_post_ov"}, bus.out_valid, 0);
        chk({tag, "_post_ir"}, bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_ir", bus.in_ready, 1);
        chk("rst_q", bus.q, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ir", bus.in_ready, 1);

        run_op("third",   16'h3F80, 16'h4040, 16'h3EAB, 5'h01, 12, 0);
        run_op("six_two", 16'h40C0, 16'h4000, 16'h4040, 5'h00, 12, 0);
        run_op("neg",     16'hBF80, 16'h4040, 16'hBEAB, 5'h01, 12, 0);
        run_op("one_one", 16'h3F80, 16'h3F80, 16'h3F80, 5'h00, 12, 0);
        run_op("dbz",     16'h3F80, 16'h0000, 16'h7F80, 5'h08, 2, 0);
        run_op("zz",      16'h0000, 16'h0000, 16'h7FC0, 5'h10, 2, 0);
        run_op("ovf",     16'h7F7F, 16'h3F00, 16'h7F80, 5'h05, 12, 0);
        run_op("inf_fin", 16'h7F80, 16'hC000, 16'hFF80, 5'h00, 2, 0);
        run_op("inf_inf", 16'h7F80, 16'hFF80, 16'h7FC0, 5'h10, 2, 0);
        run_op("qnan",    16'h7FC1, 16'h3F80, 16'h7FC0, 5'h00, 2, 0);
        run_op("snan",    16'h3F80, 16'h7F81, 16'h7FC0, 5'h10, 2, 0);
        run_op("fin_inf", 16'h3F80, 16'hFF80, 16'h8000, 5'h00, 2, 0);
        run_op("zero_n",  16'h8000, 16'h40A0, 16'h8000, 5'h00, 2, 0);
        run_op("minnorm", 16'h0100, 16'h4000, 16'h0080, 5'h00, 12, 0);
`ifdef DIV_SUBNORMAL_EN
        run_op("tiny",    16'h0080, 16'h4000, 16'h0040, 5'h00, 12, 0);
`else
        run_op("tiny",    16'h0080, 16'h4000, 16'h0000, 5'h03, 12, 0);
`endif
        run_op("bp",      16'h3F80, 16'h4040, 16'h3EAB, 5'h01, 12, 5);

        // reset in the middle of ITER discards the operation
        @(negedge clk);
        bus.a = 16'h3F80;
        bus.b = 16'h4040;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ov", bus.out_valid, 0);
        chk("mid_ir", bus.in_ready, 1);
        chk("mid_q", bus.q, 0);
        chk("mid_fl", bus.flags, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_idle", bus.out_valid, 0);
        run_op("fresh",   16'h40C0, 16'h4000, 16'h4040, 5'h00, 12, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
